// File: rtl/bounce_emulator_pkg.sv
// Shared types and LFSR helper for the bounce emulator and related stimulus blocks.
package bounce_emulator_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EDGE    = 3'd1,
        S_SEGMENT = 3'd2,
        S_SETTLE  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Galois form of x^16 + x^14 + x^13 + x^11, right-shifting.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/bounce_emulator_lfsr16.sv
// 16-bit Galois LFSR that advances only when enabled; a zero seed is forced to 1.
module bounce_emulator_lfsr16
    import bounce_emulator_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] seed_fix;

    assign seed_fix = (seed == 16'h0000) ? 16'h0001 : seed;
    assign q        = lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= seed_fix;
        end else if (en) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

endmodule

// File: rtl/bounce_emulator.sv
// Drives a 1-bit line to a target level through a burst of glitch pairs, then holds it
// for a settle period. start/level/bounces are sampled only while idle.
module bounce_emulator
    import bounce_emulator_pkg::*;
#(
    parameter int unsigned SEG_CYCLES    = 4,
    parameter logic [15:0] JITTER_MASK   = 16'h000F,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 24,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       level,
    input  logic [3:0] bounces,
    output logic       out,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state
);

    localparam longint unsigned SEG_MAX = longint'(SEG_CYCLES) + longint'(JITTER_MASK);
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    if (SEG_CYCLES < 1 || SETTLE_CYCLES < 1 || SEG_MAX > CNT_MAX
        || longint'(SETTLE_CYCLES) > CNT_MAX) begin : g_bad_params
        $error("bounce_emulator: SEG_CYCLES/JITTER_MASK/SETTLE_CYCLES do not fit CNT_W");
    end

    localparam logic [CNT_W-1:0] SEG_C        = CNT_W'(SEG_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);

    state_t           state_q;
    logic             out_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       edges_left_q;
    logic [15:0]      lfsr_q;
    logic [15:0]      jitter;
    logic [CNT_W-1:0] seg_len;

    bounce_emulator_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (busy_q),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    assign jitter  = lfsr_q & JITTER_MASK;
    assign seg_len = SEG_C + CNT_W'(jitter);

    // out toggles on the clock that enters EDGE, so out and the EDGE state are
    // visible in the same cycle; edges_left_q already counts that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            out_q        <= INIT_LEVEL;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
            edges_left_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (level != out_q) begin
                            out_q        <= ~out_q;
                            edges_left_q <= {bounces, 1'b0};
                            busy_q       <= 1'b1;
                            state_q      <= S_EDGE;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_EDGE: begin
                    if (edges_left_q == 5'd0) begin
                        if (SETTLE_CYCLES == 1) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            cnt_q   <= SETTLE_LOAD;
                            state_q <= S_SETTLE;
                        end
                    end else if (seg_len == ONE) begin
                        out_q        <= ~out_q;
                        edges_left_q <= edges_left_q - 5'd1;
                    end else begin
                        cnt_q   <= seg_len - ONE;
                        state_q <= S_SEGMENT;
                    end
                end
                S_SEGMENT: begin
                    if (cnt_q == ONE) begin
                        cnt_q        <= '0;
                        out_q        <= ~out_q;
                        edges_left_q <= edges_left_q - 5'd1;
                        state_q      <= S_EDGE;
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == ONE) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out       = out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule
